// File: rtl/neuron_mac.sv
// Sequential multiply-accumulate neuron stage: h = sat(sum(x_i * w_i) + bias) over N_INPUTS
// streamed elements, with a weight/bias config port and valid/ready handshakes on both sides.
module neuron_mac #(
    parameter int unsigned N_INPUTS = 2,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ACC_W    = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                cfg_we,
    input  logic [$clog2(N_INPUTS+1)-1:0]       cfg_addr,
    input  logic signed [DATA_W-1:0]            cfg_data,
    output logic                                cfg_ready,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic signed [DATA_W-1:0]            in_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic signed [ACC_W-1:0]             h,
    output logic                                sat
);

    localparam int unsigned AddrW = $clog2(N_INPUTS + 1);
    localparam int unsigned ProdW = 2 * DATA_W;
    localparam logic signed [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StAccum, StBias, StOut} state_e;

    state_e                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [AddrW-1:0]          idx_q, idx_d;
    logic                      sat_q, sat_d;
    logic signed [DATA_W-1:0]  w_q [N_INPUTS];
    logic signed [DATA_W-1:0]  bias_q;

    logic [AddrW-1:0]          sel_idx;
    logic signed [DATA_W-1:0]  w_sel;
    logic signed [ProdW-1:0]   prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   bias_ext;
    logic signed [ACC_W-1:0]   addend;
    logic [ACC_W:0]            sum_wide;
    logic                      ovf;
    logic signed [ACC_W-1:0]   sum_sat;
    logic                      cfg_wr;

    // The first element of a sample always pairs with w[0]; idx_q is only meaningful in ACCUM.
    assign sel_idx = (state_q == StIdle) ? '0 : idx_q;

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < int'(N_INPUTS); i++) begin
            if (sel_idx == AddrW'(i)) begin
                w_sel = w_q[i];
            end
        end
    end

    assign prod     = ProdW'(in_data) * ProdW'(w_sel);
    assign prod_ext = ACC_W'(prod);
    assign bias_ext = ACC_W'(bias_q);
    assign addend   = (state_q == StBias) ? bias_ext : prod_ext;

    // One guard bit detects signed overflow; clamp toward the sign of the true sum.
    assign sum_wide = {acc_q[ACC_W-1], acc_q} + {addend[ACC_W-1], addend};
    assign ovf      = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    assign sum_sat  = !ovf ? sum_wide[ACC_W-1:0] : (sum_wide[ACC_W] ? AccMin : AccMax);

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        sat_d     = sat_q;
        in_ready  = 1'b0;
        cfg_ready = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready  = 1'b1;
                cfg_ready = 1'b1;
                if (in_valid) begin
                    acc_d   = prod_ext;
                    idx_d   = AddrW'(1);
                    sat_d   = 1'b0;
                    state_d = (N_INPUTS == 1) ? StBias : StAccum;
                end
            end
            StAccum: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_d = sum_sat;
                    sat_d = sat_q | ovf;
                    idx_d = idx_q + AddrW'(1);
                    if (idx_q == AddrW'(N_INPUTS - 1)) begin
                        state_d = StBias;
                    end
                end
            end
            StBias: begin
                acc_d   = sum_sat;
                sat_d   = sat_q | ovf;
                state_d = StOut;
            end
            StOut: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    idx_d   = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            idx_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            sat_q   <= sat_d;
        end
    end

    // Writes land only in IDLE; an element accepted on the same edge already used the old value.
    assign cfg_wr = cfg_we & cfg_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bias_q <= '0;
            for (int i = 0; i < int'(N_INPUTS); i++) begin
                w_q[i] <= '0;
            end
        end else if (cfg_wr) begin
            for (int i = 0; i < int'(N_INPUTS); i++) begin
                if (cfg_addr == AddrW'(i)) begin
                    w_q[i] <= cfg_data;
                end
            end
            if (cfg_addr == AddrW'(N_INPUTS)) begin
                bias_q <= cfg_data;
            end
        end
    end

    assign h   = acc_q;
    assign sat = sat_q;

endmodule
